// File: rtl/cpu_host_ctrl.sv
// Host-side run controller for the single-cycle core: loads an input image, runs the core
// under a watchdog, drains a result window and reports how many cycles the run took.
module cpu_host_ctrl #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int LOAD_BASE = 0,
  parameter int LOAD_N    = 64,
  parameter int RES_BASE  = 64,
  parameter int RES_N     = 64,
  parameter int RST_CYC   = 2,
  parameter int TIMEOUT   = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  output logic          load_ready,
  output logic          res_valid,
  output logic [DW-1:0] res_data,
  input  logic          res_ready,
  output logic          mem_sel,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wr_data,
  input  logic [DW-1:0] mem_rd_data,
  output logic          core_rst,
  output logic          core_req,
  input  logic          core_done,
  output logic          busy,
  output logic          finished,
  output logic          timeout_err,
  output logic [15:0]   run_cycles
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CRST  = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4,
    FIN   = 3'd5,
    ERR   = 3'd6
  } state_t;

  localparam int RCW = $clog2(RST_CYC + 1);
  localparam int TW  = $clog2(TIMEOUT);

  localparam logic [AW:0]     LAST_LOAD = (AW+1)'(LOAD_N - 1);
  localparam logic [AW:0]     LAST_RES  = (AW+1)'(RES_N - 1);
  localparam logic [RCW-1:0]  LAST_RST  = RCW'(RST_CYC - 1);
  localparam logic [TW-1:0]   LAST_TMR  = TW'(TIMEOUT - 1);
  localparam logic [AW-1:0]   LOAD_A0   = AW'(LOAD_BASE);
  localparam logic [AW-1:0]   RES_A0    = AW'(RES_BASE);

  state_t         state;
  logic [AW:0]    ptr;
  logic [RCW-1:0] rst_cnt;
  logic [TW-1:0]  tmr;
  logic [AW-1:0]  load_addr;
  logic [AW-1:0]  res_addr;

  // ptr is one bit wider than the address so a full 2^AW window can be counted.
  assign load_addr = LOAD_A0 + ptr[AW-1:0];
  assign res_addr  = RES_A0 + ptr[AW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      rst_cnt     <= '0;
      tmr         <= '0;
      run_cycles  <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE, ERR: begin
          if (start) begin
            state       <= LOAD;
            ptr         <= '0;
            run_cycles  <= '0;
            timeout_err <= 1'b0;
          end
        end
        LOAD: begin
          if (load_valid) begin
            if (ptr == LAST_LOAD) begin
              state   <= CRST;
              ptr     <= '0;
              rst_cnt <= '0;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        CRST: begin
          if (rst_cnt == LAST_RST) begin
            state <= RUN;
            tmr   <= '0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        RUN: begin
          if (run_cycles != 16'hFFFF) begin
            run_cycles <= run_cycles + 16'd1;
          end
          // A done on the last allowed cycle still wins over the watchdog.
          if (core_done) begin
            state <= DRAIN;
            ptr   <= '0;
          end else if (tmr == LAST_TMR) begin
            state       <= ERR;
            timeout_err <= 1'b1;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        DRAIN: begin
          if (res_ready) begin
            if (ptr == LAST_RES) begin
              state <= FIN;
              ptr   <= '0;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Port outputs decode the state; reset forces them quiet before the state register clears.
  always_comb begin
    load_ready  = 1'b0;
    res_valid   = 1'b0;
    res_data    = '0;
    mem_sel     = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    core_req    = 1'b0;
    busy        = 1'b0;
    finished    = 1'b0;
    core_rst    = reset;
    if (!reset) begin
      case (state)
        LOAD: begin
          busy       = 1'b1;
          load_ready = 1'b1;
          mem_sel    = 1'b1;
          mem_addr   = load_addr;
          if (load_valid) begin
            mem_wr_en   = 1'b1;
            mem_wr_data = load_data;
          end
        end
        CRST: begin
          busy     = 1'b1;
          core_rst = 1'b1;
        end
        RUN: begin
          busy     = 1'b1;
          core_req = 1'b1;
        end
        DRAIN: begin
          busy      = 1'b1;
          mem_sel   = 1'b1;
          mem_addr  = res_addr;
          res_valid = 1'b1;
          res_data  = mem_rd_data;
        end
        FIN: begin
          busy     = 1'b1;
          finished = 1'b1;
        end
        ERR: begin
          core_rst = 1'b1;
        end
        default: begin
          core_rst = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_host_ctrl.sv
// Directed bench for cpu_host_ctrl: a 10-word window wrapping the top of memory, stalls,
// watchdog abort and restart, done on the last allowed cycle, and reset mid-run.
module tb_cpu_host_ctrl;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int N  = 10;
  localparam int TO = 32;

  logic          clk;
  logic          reset;
  logic          start;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_ready;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic          res_ready;
  logic          mem_sel;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data;
  logic          core_rst;
  logic          core_req;
  logic          core_done;
  logic          busy;
  logic          finished;
  logic          timeout_err;
  logic [15:0]   run_cycles;

  int passed = 0;
  int total  = 0;
  int failed = 0;
  int wr_count = 0;
  int wr_before;

  logic [DW-1:0] mem [256];

  cpu_host_ctrl #(
    .AW(AW), .DW(DW), .LOAD_BASE(250), .LOAD_N(N), .RES_BASE(250), .RES_N(N),
    .RST_CYC(2), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .mem_sel(mem_sel), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .core_rst(core_rst), .core_req(core_req), .core_done(core_done),
    .busy(busy), .finished(finished), .timeout_err(timeout_err), .run_cycles(run_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory shared with the core; only the host side is exercised here.
  always @(posedge clk) begin
    if (mem_sel && mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
      wr_count <= wr_count + 1;
    end
  end
  assign mem_rd_data = mem_sel ? mem[mem_addr] : 8'h00;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] wordVal(input int seed, input int i);
    return 8'((seed * 37 + i * 7 + 3) % 256);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic lv, input logic [7:0] ld,
                               input logic rr, input logic cd);
    start      = st;
    load_valid = lv;
    load_data  = ld;
    res_ready  = rr;
    core_done  = cd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Streams N words back to back from LOAD; returns in the first RUN cycle.
  task automatic loadBurst(input int seed);
    for (int i = 0; i < N; i++) begin
      applyStimulus(1'b0, 1'b1, wordVal(seed, i), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("rst_core_rst", core_rst, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_load_ready", load_ready, 0);
    checkOutput("rst_mem_sel", mem_sel, 0);
    checkOutput("rst_run_cycles", run_cycles, 0);
    checkOutput("rst_timeout_err", timeout_err, 0);
    reset = 1'b0;
    #1;
    checkOutput("idle_core_rst", core_rst, 0);

    $display("[TB] run 1: gapped load across the wrap, done after 10 cycles, stalled drain");
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("load_busy", busy, 1);
    checkOutput("load_ready", load_ready, 1);
    checkOutput("load_mem_sel", mem_sel, 1);
    for (int i = 0; i < N; i++) begin
      if (i % 3 == 1) begin
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("load_gap_wr_en", mem_wr_en, 0);
        tick();
      end
      applyStimulus(i == 4, 1'b1, wordVal(1, i), 1'b0, 1'b0);
      checkOutput("load_wr_en", mem_wr_en, 1);
      checkOutput("load_addr", mem_addr, 32'((250 + i) % 256));
      checkOutput("load_wr_data", mem_wr_data, wordVal(1, i));
      tick();
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("load_word_count", wr_count, N);
    checkOutput("wrap_mem3", mem[3], wordVal(1, 9));
    checkOutput("crst1_core_rst", core_rst, 1);
    checkOutput("crst1_load_ready", load_ready, 0);
    checkOutput("crst1_core_req", core_req, 0);
    tick();
    checkOutput("crst2_core_rst", core_rst, 1);
    tick();
    checkOutput("run1_core_rst", core_rst, 0);
    checkOutput("run1_core_req", core_req, 1);
    checkOutput("run1_mem_sel", mem_sel, 0);
    for (int k = 1; k < 10; k++) tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("drain_core_req", core_req, 0);
    checkOutput("drain_res_valid", res_valid, 1);
    checkOutput("drain_run_cycles", run_cycles, 10);
    checkOutput("drain_addr0", mem_addr, 250);
    for (int i = 0; i < N; i++) begin
      if (i % 2 == 0) begin
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("drain_stall_data", res_data, wordVal(1, i));
        tick();
        checkOutput("drain_stall_hold", res_data, wordVal(1, i));
      end
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("drain_data", res_data, wordVal(1, i));
      tick();
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("fin_pulse", finished, 1);
    checkOutput("fin_res_valid", res_valid, 0);
    tick();
    checkOutput("fin_once", finished, 0);
    checkOutput("fin_idle_busy", busy, 0);
    checkOutput("fin_timeout_err", timeout_err, 0);

    $display("[TB] run 2: core never finishes, watchdog abort");
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    loadBurst(2);
    for (int k = 1; k < TO; k++) tick();
    checkOutput("to_last_core_req", core_req, 1);
    checkOutput("to_last_flag", timeout_err, 0);
    tick();
    checkOutput("err_flag", timeout_err, 1);
    checkOutput("err_core_rst", core_rst, 1);
    checkOutput("err_core_req", core_req, 0);
    checkOutput("err_busy", busy, 0);
    checkOutput("err_run_cycles", run_cycles, TO);
    tick();
    tick();
    checkOutput("err_hold_flag", timeout_err, 1);
    checkOutput("err_hold_core_rst", core_rst, 1);

    $display("[TB] run 3: restart from ERR, done on the last allowed cycle");
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("restart_flag_clear", timeout_err, 0);
    checkOutput("restart_run_cycles", run_cycles, 0);
    checkOutput("restart_load_ready", load_ready, 1);
    loadBurst(3);
    for (int k = 1; k < TO; k++) tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("limit_res_valid", res_valid, 1);
    checkOutput("limit_flag", timeout_err, 0);
    checkOutput("limit_run_cycles", run_cycles, TO);
    checkOutput("limit_core_rst", core_rst, 0);
    for (int i = 0; i < N; i++) begin
      checkOutput("limit_drain_data", res_data, wordVal(3, i));
      tick();
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("limit_fin", finished, 1);
    tick();

    $display("[TB] run 4: reset during RUN");
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    loadBurst(4);
    tick();
    tick();
    reset = 1'b1;
    #1;
    checkOutput("rrun_core_rst", core_rst, 1);
    checkOutput("rrun_core_req", core_req, 0);
    checkOutput("rrun_busy", busy, 0);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rrun_idle_busy", busy, 0);
    checkOutput("rrun_run_cycles", run_cycles, 0);
    checkOutput("rrun_idle_core_rst", core_rst, 0);
    checkOutput("rrun_idle_core_req", core_req, 0);
    wr_before = wr_count;
    applyStimulus(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
    checkOutput("rrun_no_wr_en", mem_wr_en, 0);
    tick();
    tick();
    tick();
    checkOutput("rrun_no_writes", wr_count, wr_before);
    checkOutput("rrun_load_ready", load_ready, 0);

    $display("[TB] run 5: reset during DRAIN");
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    loadBurst(5);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("rdrn_run_cycles", run_cycles, 1);
    checkOutput("rdrn_res_valid", res_valid, 1);
    checkOutput("rdrn_data0", res_data, wordVal(5, 0));
    tick();
    tick();
    checkOutput("rdrn_addr2", mem_addr, 252);
    checkOutput("rdrn_data2", res_data, wordVal(5, 2));
    reset = 1'b1;
    #1;
    checkOutput("rdrn_rst_res_valid", res_valid, 0);
    checkOutput("rdrn_rst_mem_sel", mem_sel, 0);
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("rdrn_idle_res_valid", res_valid, 0);
    checkOutput("rdrn_idle_busy", busy, 0);
    checkOutput("rdrn_idle_run_cycles", run_cycles, 0);
    checkOutput("rdrn_idle_finished", finished, 0);
    checkOutput("rdrn_idle_addr", mem_addr, 0);
    tick();
    checkOutput("rdrn_stays_idle", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
